pipe_fetch_ctrl: RTL
====================

# pipe_fetch_ctrl

Sequencing controller for the pipelined RV32I fetch stage. It drives the PC register enable and the 3-input next-PC mux select, and generates Decode/Execute flush and fetch-valid qualifiers. It also covers the boot wait after reset, taken-branch/jump redirects with the extra bubble needed by the synchronous instruction memory, decode back-pressure, and a halt/resume handshake. It sits beside the fetch datapath and is driven by Decode/Execute control signals.

## Interface
- `BOOT_CYCLES`, default 2: cycles the PC is held after reset before fetching starts (1..15).
- `CNT_W`, default 16: width of the saturating performance counters.
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rstn`, in, 1: reset. One clock; reset is synchronous and active-low.
- `i_redirect`, in, 1: Execute resolves a taken branch/jump this cycle.
- `i_redirect_sel`, in, 2: next-PC source on redirect: 01 = PCTargetE, 10 = ALU result. 00 and 11 are illegal.
- `i_stallD`, in, 1: Decode cannot accept a new instruction.
- `i_halt`, in, 1: level request to stop fetching (ecall/ebreak/debug).
- `i_resume`, in, 1: single-cycle pulse that releases a halt.
- `o_pc_en`, out, 1: PC register enable.
- `o_pc_sel`, out, 2: next-PC mux select: 00 = PC+4, 01 = PCTargetE, 10 = ALU.
- `o_flushD`, out, 1: clear the F/D pipeline register.
- `o_flushE`, out, 1: clear the D/E pipeline register.
- `o_validF`, out, 1: the instruction presented to F/D this cycle is real.
- `o_halted`, out, 1: controller is in HALT.
- `o_redirect_cnt`, out, CNT_W: number of redirects taken, saturating.
- `o_stall_cnt`, out, CNT_W: number of cycles with RUN and `i_stallD` and no redirect, saturating.

## Operation
- FSM states: BOOT, RUN, REDIR, HALT.
- State is encoded 2-bit; every output is registered or decoded from state plus inputs. There are no combinational loops to Decode.
- **Reset** (`i_rstn`=0 at an edge):
  - State becomes BOOT and the boot counter is cleared.
  - Both performance counters are cleared.
  - Reset overrides every other input, including in mid-redirect or HALT.
- **BOOT**
  - Outputs: `o_pc_en`=0, `o_pc_sel`=00, `o_flushD`=1, `o_flushE`=1, `o_validF`=0.
  - The boot counter increments each cycle.
  - When the counter reaches BOOT_CYCLES−1, the next state is RUN.
  - All inputs are ignored.
- **RUN**, with checks in priority order:
  - If `i_redirect`: `o_pc_en`=1, `o_pc_sel`=`i_redirect_sel`, `o_flushD`=1, `o_flushE`=1, `o_validF`=0. The redirect counter increments and the next state is REDIR. This case overrides `i_stallD` and `i_halt`.
  - Else if `i_halt`: `o_pc_en`=0, `o_validF`=0, and the next state is HALT. The in-flight instruction is not flushed.
  - Else if `i_stallD`: `o_pc_en`=0, `o_validF`=1, and the stall counter increments.
  - Else: `o_pc_en`=1, `o_pc_sel`=00, `o_validF`=1.
- **REDIR**
  - Outputs: `o_pc_en`=1, `o_pc_sel`=00, `o_flushD`=1, `o_flushE`=0, `o_validF`=0. This is the synchronous-imem bubble.
  - The next state is always RUN.
  - `i_redirect`, `i_halt` and `i_stallD` are ignored in this state.
  - `i_stallD` is ignored because F/D holds a bubble.
- **HALT**
  - Outputs: `o_pc_en`=0, `o_validF`=0, `o_halted`=1.
  - `i_resume` moves the state to RUN.
  - `i_redirect` in HALT is ignored.
  - If `i_resume` and `i_halt` are both high, resume wins for one cycle; RUN then re-samples `i_halt`.
- **Counters** saturate at 2^CNT_W−1 and never wrap.
- **Illegal select:** an `i_redirect_sel` of 00 or 11 with `i_redirect`=1 is passed through unchanged. This is an assertion failure in simulation.

## Timing
- **Reset values:**
  - `o_pc_en` 0, `o_pc_sel` 00, `o_flushD` 1, `o_flushE` 1.
  - `o_validF` 0, `o_halted` 0, both counters 0.
- **First fetch:** `o_pc_en` first rises BOOT_CYCLES cycles after the reset release edge.
- **Redirect penalty:**
  - The redirect cycle plus the REDIR cycle gives exactly 2 bubbles.
  - The first valid target instruction has `o_validF`=1 two cycles after `i_redirect`.
- **Stall:** combinational from `i_stallD` to `o_pc_en` within the same cycle, with zero-latency hold.
- **Halt:** the earliest resume is one cycle after HALT is entered. RUN outputs apply in the cycle after the `i_resume` edge.

## Structure
- A shared package/header holds:
  - the state encodings FS_BOOT=0, FS_RUN=1, FS_REDIR=2, FS_HALT=3;
  - the PC select constants PCSEL_PLUS4=2'b00, PCSEL_TARGET=2'b01, PCSEL_ALU=2'b10.
- One sub-module, `pipe_sat_counter`, is instantiated twice. Its ports are enable, synchronous active-low clear and a CNT_W-bit output, and it saturates at its maximum.

## Test plan
- **Reset and boot:** reset with BOOT_CYCLES=2, then release.
  - `o_pc_en`=0 and `o_flushD`=1 for 2 cycles, then `o_pc_en`=1, `o_pc_sel`=00 and `o_validF`=1.
- **Redirect:** `i_redirect`=1 with sel=01 in RUN.
  - Same cycle: `o_pc_sel`=01, flushD=1, flushE=1.
  - Next cycle: sel=00, flushD=1, flushE=0.
  - `o_validF` returns to 1 on cycle +2, and `o_redirect_cnt`=1.
- **Redirect during stall:** `i_stallD`=1 together with `i_redirect`=1 (sel=10).
  - `o_pc_en`=1 and `o_pc_sel`=10; `o_stall_cnt` is unchanged.
- **Stall:** hold `i_stallD`=1 for 5 cycles in RUN.
  - `o_pc_en`=0 for those 5 cycles and `o_stall_cnt`=5.
- **Halt and resume:**
  - `i_halt`=1 gives `o_halted`=1 with `o_pc_en`=0 from the next cycle.
  - `i_redirect` in HALT causes no change.
  - An `i_resume` pulse returns to RUN.
- **Saturation and reset mid-operation:**
  - With CNT_W=4, 20 redirects leave `o_redirect_cnt`=15.
  - Asserting `i_rstn`=0 in REDIR returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/pipe_fetch_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch-stage sequencing controller.
// Holds the FSM state encoding, next-PC select codes and the decoded control bundle.
package pipe_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_REDIR = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_ALU    = 2'b10;

  // Wide enough for the largest boot wait (15) plus the final increment.
  localparam int unsigned BOOT_CNT_W = 4;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       flush_d;
    logic       flush_e;
    logic       valid_f;
  } fetch_ctrl_t;

  localparam fetch_ctrl_t CTRL_IDLE = '{
    pc_en:   1'b0,
    pc_sel:  PCSEL_PLUS4,
    flush_d: 1'b0,
    flush_e: 1'b0,
    valid_f: 1'b0
  };

  function automatic logic pcsel_legal(input logic [1:0] sel);
    return (sel == PCSEL_TARGET) || (sel == PCSEL_ALU);
  endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Decode/Execute-facing control bundle of the fetch controller.
// The controller uses the slave view; the pipeline (or a bench) drives the master view.
interface pipe_fetch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic             i_redirect;
  logic [1:0]       i_redirect_sel;
  logic             i_stallD;
  logic             i_halt;
  logic             i_resume;

  logic             o_pc_en;
  logic [1:0]       o_pc_sel;
  logic             o_flushD;
  logic             o_flushE;
  logic             o_validF;
  logic             o_halted;
  logic [CNT_W-1:0] o_redirect_cnt;
  logic [CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_redirect, i_redirect_sel, i_stallD, i_halt, i_resume,
    output o_pc_en, o_pc_sel, o_flushD, o_flushE, o_validF, o_halted,
    output o_redirect_cnt, o_stall_cnt
  );

  modport master (
    output i_redirect, i_redirect_sel, i_stallD, i_halt, i_resume,
    input  o_pc_en, o_pc_sel, o_flushD, o_flushE, o_validF, o_halted,
    input  o_redirect_cnt, o_stall_cnt
  );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear.
// Holds at all-ones instead of wrapping, so long runs never read back as small counts.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencing controller: boot wait, redirect bubble, decode stall and halt/resume.
// Control outputs are decoded from the state plus this cycle's inputs so stalls hold the PC at once.
module pipe_fetch_ctrl
  import pipe_fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic             i_clk,
  input logic             i_rstn,
  pipe_fetch_ctrl_if.slave bus
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  fetch_state_e            state_q;
  logic [BOOT_CNT_W-1:0]   boot_cnt_q;
  fetch_ctrl_t             ctrl;
  logic                    redirect_take;
  logic                    stall_take;

  // Redirect outranks halt and stall; halt outranks stall.
  assign redirect_take = (state_q == FS_RUN) && bus.i_redirect;
  assign stall_take    = (state_q == FS_RUN) && !bus.i_redirect && !bus.i_halt && bus.i_stallD;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= FS_BOOT;
      boot_cnt_q <= '0;
    end else begin
      case (state_q)
        FS_BOOT: begin
          boot_cnt_q <= boot_cnt_q + 1'b1;
          if (boot_cnt_q == BOOT_LAST) begin
            state_q <= FS_RUN;
          end
        end
        FS_RUN: begin
          if (bus.i_redirect) begin
            state_q <= FS_REDIR;
          end else if (bus.i_halt) begin
            state_q <= FS_HALT;
          end
        end
        FS_REDIR: state_q <= FS_RUN;
        FS_HALT: begin
          if (bus.i_resume) begin
            state_q <= FS_RUN;
          end
        end
        default: state_q <= FS_BOOT;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      FS_BOOT: begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
      FS_RUN: begin
        if (bus.i_redirect) begin
          // Select is forwarded untouched; an illegal code is caught by the assertion below.
          ctrl.pc_en   = 1'b1;
          ctrl.pc_sel  = bus.i_redirect_sel;
          ctrl.flush_d = 1'b1;
          ctrl.flush_e = 1'b1;
        end else if (bus.i_halt) begin
          ctrl.valid_f = 1'b0;
        end else if (bus.i_stallD) begin
          ctrl.valid_f = 1'b1;
        end else begin
          ctrl.pc_en   = 1'b1;
          ctrl.valid_f = 1'b1;
        end
      end
      FS_REDIR: begin
        // The synchronous imem still returns the fall-through word; squash it in F/D.
        ctrl.pc_en   = 1'b1;
        ctrl.flush_d = 1'b1;
      end
      FS_HALT: ctrl = CTRL_IDLE;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign bus.o_pc_en    = ctrl.pc_en;
  assign bus.o_pc_sel   = ctrl.pc_sel;
  assign bus.o_flushD   = ctrl.flush_d;
  assign bus.o_flushE   = ctrl.flush_e;
  assign bus.o_validF   = ctrl.valid_f;
  assign bus.o_halted   = (state_q == FS_HALT);

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk_i   (i_clk),
    .clr_n_i (i_rstn),
    .en_i    (redirect_take),
    .cnt_o   (bus.o_redirect_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (i_clk),
    .clr_n_i (i_rstn),
    .en_i    (stall_take),
    .cnt_o   (bus.o_stall_cnt)
  );

  a_redirect_sel_legal: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    bus.i_redirect |-> pcsel_legal(bus.i_redirect_sel)
  );

  a_no_fetch_in_halt: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    (state_q == FS_HALT) |-> (!ctrl.pc_en && !ctrl.valid_f)
  );

  a_redir_returns_to_run: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    (state_q == FS_REDIR) |=> (state_q == FS_RUN)
  );

endmodule
